// File: rtl/abs_diff_scheduler.sv
// abs_diff_scheduler: shares one external combinational |a-b| unit across the
// NUM_NB neighbours of a filter window. Each accepted window is walked one
// neighbour per cycle, building a similarity mask, a similar-neighbour count
// and the sum of absolute differences, which are then held for the consumer.
module abs_diff_scheduler #(
  parameter int PIX_W  = 8,
  parameter int NUM_NB = 8,
  parameter int IDX_W  = 3,
  parameter int CNT_W  = 4,
  parameter int SUM_W  = 11
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [PIX_W-1:0]        centre,
  input  logic [NUM_NB*PIX_W-1:0] nbrs,
  input  logic [PIX_W-1:0]        threshold,
  output logic [PIX_W-1:0]        abs_a,
  output logic [PIX_W-1:0]        abs_b,
  input  logic [PIX_W-1:0]        abs_res,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NUM_NB-1:0]       sim_mask,
  output logic [CNT_W-1:0]        sim_count,
  output logic [SUM_W-1:0]        sad_sum
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                    state_r;
  logic [IDX_W-1:0]          idx_r;
  logic [PIX_W-1:0]          centre_r;
  logic [PIX_W-1:0]          thr_r;
  logic [NUM_NB*PIX_W-1:0]   nbrs_r;
  logic [NUM_NB-1:0]         mask_acc_r;
  logic [CNT_W-1:0]          cnt_acc_r;
  logic [SUM_W-1:0]          sum_acc_r;

  logic [PIX_W-1:0]          nb_arr_s [NUM_NB];
  logic [PIX_W-1:0]          nb_sel_s;
  logic                      similar_s;
  logic                      last_s;
  logic [NUM_NB-1:0]         mask_next_s;
  logic [CNT_W-1:0]          cnt_next_s;
  logic [SUM_W-1:0]          sum_next_s;

  // Accept only in IDLE, and never while reset is asserted.
  assign in_ready = rst_n & (state_r == IDLE);

  // Unpack the captured neighbours so the current one can be selected by index.
  always_comb begin
    for (int k = 0; k < NUM_NB; k++) begin
      nb_arr_s[k] = nbrs_r[k*PIX_W +: PIX_W];
    end
  end

  assign nb_sel_s  = nb_arr_s[idx_r];
  assign similar_s = (abs_res <= thr_r);
  assign last_s    = (idx_r == IDX_W'(NUM_NB - 1));

  // Next accumulator values for the neighbour being processed this cycle.
  always_comb begin
    mask_next_s = mask_acc_r;
    for (int k = 0; k < NUM_NB; k++) begin
      if (idx_r == IDX_W'(k)) begin
        mask_next_s[k] = similar_s;
      end else begin
        mask_next_s[k] = mask_acc_r[k];
      end
    end
    cnt_next_s = cnt_acc_r + {{(CNT_W-1){1'b0}}, similar_s};
    sum_next_s = sum_acc_r + {{(SUM_W-PIX_W){1'b0}}, abs_res};
  end

  // Drive the shared abs-diff unit only while walking the neighbours.
  always_comb begin
    if (state_r == RUN) begin
      abs_a = centre_r;
      abs_b = nb_sel_s;
    end else begin
      abs_a = {PIX_W{1'b0}};
      abs_b = {PIX_W{1'b0}};
    end
  end

  // Window FSM: capture, walk NUM_NB neighbours, hold the result until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      idx_r      <= {IDX_W{1'b0}};
      centre_r   <= {PIX_W{1'b0}};
      thr_r      <= {PIX_W{1'b0}};
      nbrs_r     <= {(NUM_NB*PIX_W){1'b0}};
      mask_acc_r <= {NUM_NB{1'b0}};
      cnt_acc_r  <= {CNT_W{1'b0}};
      sum_acc_r  <= {SUM_W{1'b0}};
      out_valid  <= 1'b0;
      sim_mask   <= {NUM_NB{1'b0}};
      sim_count  <= {CNT_W{1'b0}};
      sad_sum    <= {SUM_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            centre_r   <= centre;
            thr_r      <= threshold;
            nbrs_r     <= nbrs;
            mask_acc_r <= {NUM_NB{1'b0}};
            cnt_acc_r  <= {CNT_W{1'b0}};
            sum_acc_r  <= {SUM_W{1'b0}};
            idx_r      <= {IDX_W{1'b0}};
            state_r    <= RUN;
          end else begin
            state_r    <= IDLE;
          end
        end
        RUN: begin
          mask_acc_r <= mask_next_s;
          cnt_acc_r  <= cnt_next_s;
          sum_acc_r  <= sum_next_s;
          if (last_s) begin
            // Publish the final totals; they stay put until the next window ends.
            sim_mask  <= mask_next_s;
            sim_count <= cnt_next_s;
            sad_sum   <= sum_next_s;
            out_valid <= 1'b1;
            idx_r     <= {IDX_W{1'b0}};
            state_r   <= DONE;
          end else begin
            idx_r     <= idx_r + IDX_W'(1);
            state_r   <= RUN;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_r   <= IDLE;
          end else begin
            out_valid <= 1'b1;
            state_r   <= DONE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          idx_r     <= {IDX_W{1'b0}};
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_abs_diff_scheduler.sv
// Directed bench for abs_diff_scheduler with a behavioural abs-diff unit.
module tb_abs_diff_scheduler;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  centre;
  logic [63:0] nbrs;
  logic [7:0]  threshold;
  logic [7:0]  abs_a;
  logic [7:0]  abs_b;
  logic [7:0]  abs_res;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  sim_mask;
  logic [3:0]  sim_count;
  logic [10:0] sad_sum;

  int total;
  int bad;

  abs_diff_scheduler dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .centre(centre), .nbrs(nbrs), .threshold(threshold),
    .abs_a(abs_a), .abs_b(abs_b), .abs_res(abs_res),
    .out_valid(out_valid), .out_ready(out_ready),
    .sim_mask(sim_mask), .sim_count(sim_count), .sad_sum(sad_sum)
  );

  // External shared absolute-difference unit.
  assign abs_res = (abs_a > abs_b) ? (abs_a - abs_b) : (abs_b - abs_a);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    #3;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%0b want=0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0b want=0", out_valid); end
    total++; if (sim_mask !== 8'h00 || sim_count !== 4'd0 || sad_sum !== 11'd0)
      begin bad++; $display("FAIL rst_outputs got=%h/%0d/%0d want=0/0/0", sim_mask, sim_count, sad_sum); end
    total++; if (abs_a !== 8'd0 || abs_b !== 8'd0)
      begin bad++; $display("FAIL rst_abs got=%0d/%0d want=0/0", abs_a, abs_b); end
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%0b want=1", in_ready); end
  endtask

  task automatic test_basic();
    logic [7:0]  cv [3];
    logic [63:0] nv [3];
    logic [7:0]  tv [3];
    logic [7:0]  em [3];
    logic [3:0]  ec [3];
    logic [10:0] es [3];
    int lat;
    cv[0] = 8'd100; nv[0] = 64'h6464_6464_6464_6464; tv[0] = 8'd0;
    em[0] = 8'hFF;  ec[0] = 4'd8; es[0] = 11'd0;
    cv[1] = 8'd0;   nv[1] = 64'hFFFF_FFFF_FFFF_FFFF; tv[1] = 8'd254;
    em[1] = 8'h00;  ec[1] = 4'd0; es[1] = 11'd2040;
    cv[2] = 8'd50;  nv[2] = 64'h37FF_0027_3D32_283C; tv[2] = 8'd10;
    em[2] = 8'b1000_0111; ec[2] = 4'd4; es[2] = 11'd302;
    for (int v = 0; v < 3; v++) begin
      centre = cv[v]; nbrs = nv[v]; threshold = tv[v]; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      centre = 8'hAA; nbrs = 64'h0123_4567_89AB_CDEF; threshold = 8'h00;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL basic%0d_busy got=%0b want=0", v, in_ready); end
      lat = 0;
      while (out_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
      total++; if (lat !== 8) begin bad++; $display("FAIL basic%0d_latency got=%0d want=8", v, lat); end
      total++; if (sim_mask !== em[v]) begin bad++; $display("FAIL basic%0d_mask got=%h want=%h", v, sim_mask, em[v]); end
      total++; if (sim_count !== ec[v]) begin bad++; $display("FAIL basic%0d_count got=%0d want=%0d", v, sim_count, ec[v]); end
      total++; if (sad_sum !== es[v]) begin bad++; $display("FAIL basic%0d_sad got=%0d want=%0d", v, sad_sum, es[v]); end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
        begin bad++; $display("FAIL basic%0d_release got=%0b/%0b want=0/1", v, out_valid, in_ready); end
      total++; if (sim_mask !== em[v] || sad_sum !== es[v])
        begin bad++; $display("FAIL basic%0d_hold got=%h/%0d want=%h/%0d", v, sim_mask, sad_sum, em[v], es[v]); end
    end
  endtask

  task automatic test_stall();
    int lat;
    centre = 8'd50; nbrs = 64'h37FF_0027_3D32_283C; threshold = 8'd10; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
    total++; if (lat !== 8) begin bad++; $display("FAIL stall_latency got=%0d want=8", lat); end
    centre = 8'd1; nbrs = 64'd0; threshold = 8'd0; in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || sim_mask !== 8'b1000_0111 ||
          sim_count !== 4'd4 || sad_sum !== 11'd302 || abs_a !== 8'd0 || abs_b !== 8'd0) begin
        bad++;
        $display("FAIL stall_c%0d got v=%0b r=%0b m=%h c=%0d s=%0d a=%0d b=%0d want 1 0 87 4 302 0 0",
                 c, out_valid, in_ready, sim_mask, sim_count, sad_sum, abs_a, abs_b);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin bad++; $display("FAIL stall_release got=%0b/%0b want=0/1", out_valid, in_ready); end
    centre = 8'd100; nbrs = 64'h6464_6464_6464_6464; threshold = 8'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_next_accept got=%0b want=0", in_ready); end
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
    total++; if (lat !== 8 || sim_mask !== 8'hFF || sim_count !== 4'd8 || sad_sum !== 11'd0)
      begin bad++; $display("FAIL stall_next_result got=%0d/%h/%0d/%0d want=8/ff/8/0", lat, sim_mask, sim_count, sad_sum); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat;
    centre = 8'd50; nbrs = 64'h37FF_0027_3D32_283C; threshold = 8'd10; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    total++; if (abs_a !== 8'd50 || abs_b !== 8'd39)
      begin bad++; $display("FAIL mid_idx4_operands got=%0d/%0d want=50/39", abs_a, abs_b); end
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || abs_a !== 8'd0 || abs_b !== 8'd0)
      begin bad++; $display("FAIL mid_rst_ctrl got=%0b/%0b/%0d/%0d want=0/0/0/0", out_valid, in_ready, abs_a, abs_b); end
    total++; if (sim_mask !== 8'h00 || sim_count !== 4'd0 || sad_sum !== 11'd0)
      begin bad++; $display("FAIL mid_rst_outputs got=%h/%0d/%0d want=0/0/0", sim_mask, sim_count, sad_sum); end
    #20 rst_n = 1'b1;
    lat = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) lat++;
    end
    total++; if (lat !== 0) begin bad++; $display("FAIL mid_no_output got=%0d want=0", lat); end
    centre = 8'd0; nbrs = 64'hFFFF_FFFF_FFFF_FFFF; threshold = 8'd254; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
    total++; if (lat !== 8 || sim_mask !== 8'h00 || sim_count !== 4'd0 || sad_sum !== 11'd2040)
      begin bad++; $display("FAIL mid_after_result got=%0d/%h/%0d/%0d want=8/00/0/2040", lat, sim_mask, sim_count, sad_sum); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [63:0] nv;
    logic [7:0]  nb;
    int p;
    nv = 64'h37FF_0027_3D32_283C;
    centre = 8'd50; nbrs = nv; threshold = 8'd10;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(posedge clk); #1;
      p = (cyc - 1) % 10;
      if (p < 8) begin
        nb = nv[p*8 +: 8];
        total++; if (abs_a !== 8'd50 || abs_b !== nb || in_ready !== 1'b0)
          begin bad++; $display("FAIL b2b_run%0d got=%0d/%0d/%0b want=50/%0d/0", cyc, abs_a, abs_b, in_ready, nb); end
      end else if (p == 8) begin
        total++; if (out_valid !== 1'b1 || sim_mask !== 8'b1000_0111 || sad_sum !== 11'd302 || abs_a !== 8'd0 || abs_b !== 8'd0)
          begin bad++; $display("FAIL b2b_done%0d got=%0b/%h/%0d/%0d/%0d want=1/87/302/0/0", cyc, out_valid, sim_mask, sad_sum, abs_a, abs_b); end
      end else begin
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || abs_a !== 8'd0 || abs_b !== 8'd0)
          begin bad++; $display("FAIL b2b_idle%0d got=%0b/%0b/%0d/%0d want=1/0/0/0", cyc, in_ready, out_valid, abs_a, abs_b); end
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    centre = 8'd0; nbrs = 64'd0; threshold = 8'd0;
    test_reset();
    test_basic();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
